// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lift_pkg
// Description : Shared types and helpers for the lift car controller: FSM
//               state encoding, one-hot hall request codes and the
//               request -> target floor / call direction decode.
// Revision    : 1.0  initial release
// ============================================================================
package lift_pkg;

  localparam int FLOOR_W = 2;
  localparam int REQ_W   = 6;

  localparam logic [FLOOR_W-1:0] FLOOR_MIN = 2'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_MAX = 2'd3;

  // One-hot hall requests as delivered by the request buffer
  localparam logic [REQ_W-1:0] REQ_1U = 6'b000001;
  localparam logic [REQ_W-1:0] REQ_2U = 6'b000010;
  localparam logic [REQ_W-1:0] REQ_3U = 6'b000100;
  localparam logic [REQ_W-1:0] REQ_2D = 6'b001000;
  localparam logic [REQ_W-1:0] REQ_3D = 6'b010000;
  localparam logic [REQ_W-1:0] REQ_4D = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_MOVE  = 3'd2,
    ST_DOOR  = 3'd3,
    ST_CLOSE = 3'd4
  } lift_state_e;

  typedef struct packed {
    logic               valid;   // request was exactly one-hot
    logic [FLOOR_W-1:0] target;  // floor index 0..3
    logic               up;      // hall call direction, 1 = up
  } req_dec_t;

  // Any pattern other than a single known bit (zero or multi-bit) is invalid
  function automatic req_dec_t decode_req(input logic [REQ_W-1:0] req);
    req_dec_t d;
    d       = '0;
    d.valid = 1'b1;
    case (req)
      REQ_1U:  begin d.target = 2'd0; d.up = 1'b1; end
      REQ_2U:  begin d.target = 2'd1; d.up = 1'b1; end
      REQ_3U:  begin d.target = 2'd2; d.up = 1'b1; end
      REQ_2D:  begin d.target = 2'd1; d.up = 1'b0; end
      REQ_3D:  begin d.target = 2'd2; d.up = 1'b0; end
      REQ_4D:  begin d.target = 2'd3; d.up = 1'b0; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lift_timer.sv
`default_nettype none
// ============================================================================
// Module      : lift_timer
// Description : Loadable down-counter shared by the travel and door phases.
//               Load has priority over decrement; the count saturates at 0
//               and expired_o flags the zero value.
// Revision    : 1.0  initial release
// ============================================================================
module lift_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q;

  // Count register: load a fresh interval or step down towards zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lift_controller.sv
`default_nettype none
// ============================================================================
// Module      : lift_controller
// Description : Lift car controller. Pulls one hall request per service from
//               the upstream buffer, travels floor by floor, opens and closes
//               the door, then reports idle again. All outputs are decoded
//               from registered state only.
// Revision    : 1.0  initial release
// ============================================================================
module lift_controller
  import lift_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_W-1:0]   button_in,
  input  logic               q_empty,
  output logic               done,
  output logic [FLOOR_W-1:0] floor,
  output logic               motor_on,
  output logic               dir_up,
  output logic               door_open,
  output logic               hall_up,
  output logic               err_req
);

  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  lift_state_e        state_q,   state_d;
  logic [FLOOR_W-1:0] floor_q,   floor_d;
  logic [FLOOR_W-1:0] target_q,  target_d;
  logic               dir_up_q,  dir_up_d;
  logic               hall_up_q, hall_up_d;
  logic               err_q,     err_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_value;
  logic               tmr_dec;
  logic               tmr_expired;

  req_dec_t           req_dec;
  logic [FLOOR_W-1:0] floor_step;

  lift_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .dec_i     (tmr_dec),
    .expired_o (tmr_expired)
  );

  assign req_dec = decode_req(button_in);

  // Next floor in the travel direction, clamped so the car never wraps
  always_comb begin
    floor_step = floor_q;
    if (dir_up_q) begin
      if (floor_q != FLOOR_MAX) floor_step = floor_q + 2'd1;
    end else begin
      if (floor_q != FLOOR_MIN) floor_step = floor_q - 2'd1;
    end
  end

  // Next-state logic: request pickup, travel, door dwell and close
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    target_d  = target_q;
    dir_up_d  = dir_up_q;
    hall_up_d = hall_up_q;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The buffer presents a fresh request on this same edge, so the
        // request itself is only sampled in LATCH.
        if (!q_empty) state_d = ST_LATCH;
      end

      ST_LATCH: begin
        if (!req_dec.valid) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          target_d  = req_dec.target;
          hall_up_d = req_dec.up;
          tmr_load  = 1'b1;
          if (req_dec.target == floor_q) begin
            tmr_value = DOOR_LOAD;
            state_d   = ST_DOOR;
          end else begin
            tmr_value = TRAVEL_LOAD;
            dir_up_d  = (req_dec.target > floor_q);
            state_d   = ST_MOVE;
          end
        end
      end

      ST_MOVE: begin
        if (tmr_expired) begin
          floor_d  = floor_step;
          tmr_load = 1'b1;
          if (floor_step == target_q) begin
            tmr_value = DOOR_LOAD;
            state_d   = ST_DOOR;
          end else begin
            tmr_value = TRAVEL_LOAD;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_DOOR: begin
        if (tmr_expired) state_d = ST_CLOSE;
        else             tmr_dec = 1'b1;
      end

      ST_CLOSE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and car registers; reset abandons any request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      floor_q   <= '0;
      target_q  <= '0;
      dir_up_q  <= 1'b0;
      hall_up_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
      hall_up_q <= hall_up_d;
      err_q     <= err_d;
    end
  end

  // Moore output decode. The malformed-request flag is registered so it
  // carries no path from button_in; it pulses for the cycle after LATCH.
  assign done      = (state_q == ST_IDLE);
  assign floor     = floor_q;
  assign motor_on  = (state_q == ST_MOVE);
  assign dir_up    = (state_q == ST_MOVE) & dir_up_q;
  assign door_open = (state_q == ST_DOOR);
  assign hall_up   = (state_q == ST_DOOR) & hall_up_q;
  assign err_req   = err_q;

endmodule
`default_nettype wire
